delta_reconstruct: RTL and testbench
====================================

Name: delta_reconstruct

Overview:
Downstream consumer of the delta spike encoder. Takes the 2-bit up/down spike stream plus the encoder's step (threshold) and rebuilds a saturating DATA_W-bit estimate of the original sample. Each spike event is queued as {direction, estimate} in a small FIFO with a valid/ready output. Per-window up/down event counts are also published for rate monitoring.

Parameters:
DATA_W, 4, width of step, estimate and load value
DEPTH, 4, event FIFO entries (power of two, >=2)
WINDOW, 16, cycles per rate-measurement window (>=2)
CNT_W, 5, width of window event counters (must hold WINDOW)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  advance enable; when low all state holds except FIFO pop
spike  in  2  [1]=up event, [0]=down event; 2'b11 illegal
step  in  DATA_W  magnitude added/subtracted per event
load  in  1  force estimate to load_value
load_value  in  DATA_W  value for load
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head entry when out_valid
out_dir  out  1  head entry direction, 1=up, 0=down
out_value  out  DATA_W  head entry estimate after the event
estimate  out  DATA_W  current reconstructed value (registered)
up_rate  out  CNT_W  up events in last completed window
down_rate  out  CNT_W  down events in last completed window
stats_valid  out  1  one-cycle pulse when rates update
overflow  out  1  sticky: event dropped on full FIFO
illegal  out  1  sticky: spike==2'b11 seen with en high

Behaviour:
- Reset (async assert, sync-safe deassert by use): estimate=0, FIFO empty, out_valid=0, out_dir=0, out_value=0, up_rate=0, down_rate=0, stats_valid=0, overflow=0, illegal=0, window counter=0.
- Event classification (en=1): 2'b10 up, 2'b01 down, 2'b00 none, 2'b11 illegal -> no estimate change, no push, illegal<=1.
- Estimate update, one-cycle latency: spike at edge N visible on estimate after edge N.
  - up: estimate <= min(estimate+step, 2^DATA_W-1); compute in DATA_W+1 bits.
  - down: estimate <= max(estimate-step, 0).
  - step=0: estimate unchanged, event still pushed and counted.
- load priority: load=1 with en=1 sets estimate=load_value, overrides spike for estimate; spike still pushed (value field = load_value) and counted. No push on load alone.
- FIFO push: each legal event pushes {dir, new estimate}. Entry reaches out_* one edge after spike if FIFO was empty (out_valid rises same cycle estimate updates). out_dir/out_value hold the head entry; stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at edge; independent of en.
- Full: push with simultaneous pop succeeds (count unchanged). Push while full without pop: event dropped from FIFO, estimate still updates, counters still count, overflow<=1.
- Empty: out_ready ignored; out_value holds last popped value.
- Pointers wrap modulo DEPTH; occupancy tracked with DEPTH+1 states.
- Window: counter increments on each en cycle, 0..WINDOW-1. At en cycle with count WINDOW-1: up_rate/down_rate <= running counts including that cycle's event, stats_valid=1 for that next cycle, running counts and window counter clear. Running counts saturate at 2^CNT_W-1.
- en=0: estimate, window, counts, sticky flags hold; spike/load ignored; stats_valid=0.
- Sticky flags clear only on reset.
- Reset mid-operation: FIFO contents discarded immediately, out_valid falls asynchronously.

Test Plan:
- Reset then step=3, en=1, spikes up,up,up,down -> estimate 3,6,9,6; FIFO outputs (1,3),(1,6),(1,9),(0,6) with out_ready=1.
- Saturation: load_value=14 via load, then up step=5 -> estimate 15; down step=15 twice -> 0, 0; entries carry 15,0,0.
- out_ready=0, five up events (DEPTH=4) -> first four entries retained in order, overflow=1, estimate still reflects all five; then push+pop same cycle at full -> no new overflow event, count stays 4.
- spike=2'b11 with en=1 -> illegal=1, estimate unchanged, out_valid stays 0; en=0 with spike=2'b10 -> nothing changes.
- WINDOW=16: 5 up, 3 down spread over 16 en cycles, last event on cycle 16 -> stats_valid pulses once, up_rate=5, down_rate=3; next window counts restart at 0.
- Assert reset with 3 entries queued and window mid-count -> out_valid=0 immediately, all outputs zero, flags cleared.

Source files
------------

// File: rtl/delta_reconstruct.sv
`default_nettype none
// ============================================================================
//  Module      : delta_reconstruct
//  Description : Rebuilds a saturating estimate from an up/down spike stream.
//                Each legal spike is queued as {direction, estimate} in a small
//                valid/ready FIFO, and per-window up/down event counts are
//                published for rate monitoring.
//  Revision    : 1.0 - initial release
// ============================================================================
module delta_reconstruct #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        spike,
    input  logic [DATA_W-1:0] step,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_dir,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] estimate,
    output logic [CNT_W-1:0]  up_rate,
    output logic [CNT_W-1:0]  down_rate,
    output logic              stats_valid,
    output logic              overflow,
    output logic              illegal
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = $clog2(DEPTH + 1);
    localparam int c_WIN_W = $clog2(WINDOW);

    localparam logic [c_OCC_W-1:0] c_FULL     = c_OCC_W'(DEPTH);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);
    localparam logic [DATA_W-1:0]  c_EST_MAX  = '1;
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    // Event FIFO storage: bit DATA_W is the direction, lower bits the estimate
    logic [DATA_W:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_count;

    logic [c_WIN_W-1:0]    r_win;
    logic [CNT_W-1:0]      r_up_cnt;
    logic [CNT_W-1:0]      r_dn_cnt;

    logic                  w_up;
    logic                  w_dn;
    logic                  w_evt;
    logic                  w_bad;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W-1:0]     w_next_est;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [c_PTR_W-1:0]    w_last_ptr;
    logic [DATA_W:0]       w_head;
    logic [CNT_W-1:0]      w_up_cnt_nxt;
    logic [CNT_W-1:0]      w_dn_cnt_nxt;

    // Classify the spike and compute the saturated next estimate
    always_comb begin
        w_up   = en && (spike == 2'b10);
        w_dn   = en && (spike == 2'b01);
        w_bad  = en && (spike == 2'b11);
        w_evt  = w_up || w_dn;
        // One extra bit catches carry on the way up and borrow on the way down
        w_sum  = {1'b0, estimate} + {1'b0, step};
        w_diff = {1'b0, estimate} - {1'b0, step};
        w_next_est = estimate;
        if (en && load) begin
            w_next_est = load_value;
        end else if (w_up) begin
            w_next_est = w_sum[DATA_W] ? c_EST_MAX : w_sum[DATA_W-1:0];
        end else if (w_dn) begin
            w_next_est = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
        end
    end

    // FIFO handshake decode and head selection
    always_comb begin
        w_full     = (r_count == c_FULL);
        w_pop      = (r_count != '0) && out_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge
        w_push     = w_evt && (!w_full || w_pop);
        w_last_ptr = r_rd_ptr - 1'b1;
        // When empty, the slot just behind the read pointer is the last popped entry
        w_head     = (r_count == '0) ? r_mem[w_last_ptr] : r_mem[r_rd_ptr];
        out_valid  = (r_count != '0);
        out_dir    = w_head[DATA_W];
        out_value  = w_head[DATA_W-1:0];
    end

    // Saturating running event counts including this cycle's event
    always_comb begin
        w_up_cnt_nxt = (w_up && (r_up_cnt != c_CNT_MAX)) ? r_up_cnt + CNT_W'(1) : r_up_cnt;
        w_dn_cnt_nxt = (w_dn && (r_dn_cnt != c_CNT_MAX)) ? r_dn_cnt + CNT_W'(1) : r_dn_cnt;
    end

    // Estimate, window accounting and sticky error flags advance only with en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estimate    <= '0;
            r_win       <= '0;
            r_up_cnt    <= '0;
            r_dn_cnt    <= '0;
            up_rate     <= '0;
            down_rate   <= '0;
            stats_valid <= 1'b0;
            overflow    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            if (en) begin
                estimate <= w_next_est;
                if (w_bad) begin
                    illegal <= 1'b1;
                end
                if (w_evt && w_full && !w_pop) begin
                    overflow <= 1'b1;
                end
                if (r_win == c_WIN_LAST) begin
                    up_rate     <= w_up_cnt_nxt;
                    down_rate   <= w_dn_cnt_nxt;
                    stats_valid <= 1'b1;
                    r_up_cnt    <= '0;
                    r_dn_cnt    <= '0;
                    r_win       <= '0;
                end else begin
                    r_up_cnt    <= w_up_cnt_nxt;
                    r_dn_cnt    <= w_dn_cnt_nxt;
                    r_win       <= r_win + 1'b1;
                end
            end
        end
    end

    // Event FIFO: storage is cleared on reset so the empty head reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_up, w_next_est};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delta_reconstruct.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delta_reconstruct
//  Description : Self-checking bench for delta_reconstruct: queue-based
//                reference model, per-cycle compare, directed and random
//                stimulus with hand-computed anchor values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delta_reconstruct;

    localparam int DW     = 4;
    localparam int DEPTH  = 4;
    localparam int WINDOW = 16;
    localparam int CW     = 5;
    localparam int EMAX   = (1 << DW) - 1;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    spike;
    logic [DW-1:0] step;
    logic          load;
    logic [DW-1:0] load_value;
    logic          out_valid;
    logic          out_ready;
    logic          out_dir;
    logic [DW-1:0] out_value;
    logic [DW-1:0] estimate;
    logic [CW-1:0] up_rate;
    logic [CW-1:0] down_rate;
    logic          stats_valid;
    logic          overflow;
    logic          illegal;
    logic          probe = 1'b0;

    always #5 clk = ~clk;

    delta_reconstruct #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .spike       (spike),
        .step        (step),
        .load        (load),
        .load_value  (load_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dir     (out_dir),
        .out_value   (out_value),
        .estimate    (estimate),
        .up_rate     (up_rate),
        .down_rate   (down_rate),
        .stats_valid (stats_valid),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int dir;
        int val;
    } ent_t;

    ent_t q[$];
    int   m_est, m_up_cnt, m_dn_cnt, m_win, m_up_rate, m_dn_rate;
    int   m_stats, m_ovf, m_ill, m_last_dir, m_last_val;
    int   m_full, m_pop, m_up, m_dn, m_nv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_est = 0; m_up_cnt = 0; m_dn_cnt = 0; m_win = 0;
            m_up_rate = 0; m_dn_rate = 0; m_stats = 0;
            m_ovf = 0; m_ill = 0; m_last_dir = 0; m_last_val = 0;
        end else begin
            m_full  = (q.size() == DEPTH) ? 1 : 0;
            m_pop   = (q.size() > 0 && out_ready) ? 1 : 0;
            m_stats = 0;
            if (m_pop != 0) begin
                m_last_dir = q[0].dir;
                m_last_val = q[0].val;
                void'(q.pop_front());
            end
            if (en) begin
                m_up = (spike == 2'b10) ? 1 : 0;
                m_dn = (spike == 2'b01) ? 1 : 0;
                if (spike == 2'b11) m_ill = 1;
                if (load)          m_nv = int'(load_value);
                else if (m_up != 0) m_nv = (m_est + int'(step) > EMAX) ? EMAX : m_est + int'(step);
                else if (m_dn != 0) m_nv = (m_est - int'(step) < 0) ? 0 : m_est - int'(step);
                else               m_nv = m_est;
                m_est = m_nv;
                if (m_up != 0 || m_dn != 0) begin
                    if (m_full != 0 && m_pop == 0) m_ovf = 1;
                    else q.push_back('{m_up, m_nv});
                end
                if (m_up != 0 && m_up_cnt < CMAX) m_up_cnt++;
                if (m_dn != 0 && m_dn_cnt < CMAX) m_dn_cnt++;
                if (m_win == WINDOW - 1) begin
                    m_up_rate = m_up_cnt;
                    m_dn_rate = m_dn_cnt;
                    m_stats   = 1;
                    m_up_cnt  = 0;
                    m_dn_cnt  = 0;
                    m_win     = 0;
                end else begin
                    m_win++;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int tests = 0;
    int fails = 0;
    int lit_seq = 0;
    int lit_done = 0;
    int lit_est, lit_up, lit_dn, lit_ovf, lit_ill;
    int e_dir, e_val;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or posedge probe) begin
        if (q.size() > 0) begin
            e_dir = q[0].dir;
            e_val = q[0].val;
        end else begin
            e_dir = m_last_dir;
            e_val = m_last_val;
        end
        chk("out_valid",   int'(out_valid),   (q.size() > 0) ? 1 : 0);
        chk("out_dir",     int'(out_dir),     e_dir);
        chk("out_value",   int'(out_value),   e_val);
        chk("estimate",    int'(estimate),    m_est);
        chk("up_rate",     int'(up_rate),     m_up_rate);
        chk("down_rate",   int'(down_rate),   m_dn_rate);
        chk("stats_valid", int'(stats_valid), m_stats);
        chk("overflow",    int'(overflow),    m_ovf);
        chk("illegal",     int'(illegal),     m_ill);
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            chk("lit_estimate", int'(estimate), lit_est);
            if (lit_up  >= 0) chk("lit_up_rate",   int'(up_rate),   lit_up);
            if (lit_dn  >= 0) chk("lit_down_rate", int'(down_rate), lit_dn);
            if (lit_ovf >= 0) chk("lit_overflow",  int'(overflow),  lit_ovf);
            if (lit_ill >= 0) chk("lit_illegal",   int'(illegal),   lit_ill);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit e, input logic [1:0] s, input bit ld, input int lv,
                       input int st, input bit rdy);
        @(negedge clk);
        en         = e;
        spike      = s;
        load       = ld;
        load_value = DW'(lv);
        step       = DW'(st);
        out_ready  = rdy;
    endtask

    // Hand-computed value expected after the cycle just driven (-1 = skip)
    task automatic lit(input int est, input int upr, input int dnr, input int ovf, input int ill);
        #2;
        lit_est = est; lit_up = upr; lit_dn = dnr; lit_ovf = ovf; lit_ill = ill;
        lit_seq++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        en = 1'b0; spike = 2'b00; load = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [1:0] pat [16];
    int r;

    initial begin
        reset = 1'b1; en = 1'b0; spike = 2'b00; load = 1'b0;
        load_value = '0; step = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Basic reconstruction and FIFO ordering
        cyc(1, 2'b10, 0, 0, 3, 1); lit(3, 0, 0, 0, 0);
        cyc(1, 2'b10, 0, 0, 3, 1); lit(6, -1, -1, -1, -1);
        cyc(1, 2'b10, 0, 0, 3, 1); lit(9, -1, -1, -1, -1);
        cyc(1, 2'b01, 0, 0, 3, 1); lit(6, -1, -1, -1, -1);
        cyc(1, 2'b00, 0, 0, 3, 1);
        cyc(1, 2'b00, 0, 0, 3, 1);

        // Saturation at both ends, load alone pushes nothing
        do_reset();
        cyc(1, 2'b00, 1, 14, 0, 1); lit(14, -1, -1, -1, -1);
        cyc(1, 2'b10, 0, 0, 5, 1);  lit(15, -1, -1, -1, -1);
        cyc(1, 2'b01, 0, 0, 15, 1); lit(0, -1, -1, -1, -1);
        cyc(1, 2'b01, 0, 0, 15, 1); lit(0, -1, -1, 0, -1);
        cyc(1, 2'b00, 0, 0, 0, 1);

        // Overflow on full FIFO, then push+pop at full
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 2'b10, 0, 0, 1, 0); lit(i, -1, -1, 0, -1);
        end
        cyc(1, 2'b10, 0, 0, 1, 0); lit(5, -1, -1, 1, -1);
        cyc(1, 2'b10, 0, 0, 1, 1); lit(6, -1, -1, 1, -1);
        repeat (5) cyc(1, 2'b00, 0, 0, 1, 1);

        // Illegal spike and en low
        do_reset();
        cyc(1, 2'b11, 0, 0, 3, 1); lit(0, -1, -1, 0, 1);
        cyc(0, 2'b10, 0, 0, 3, 1); lit(0, -1, -1, 0, 1);
        cyc(0, 2'b00, 0, 0, 3, 1);

        // One full rate window: 5 up, 3 down, last event on cycle 16
        do_reset();
        pat = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00,
                2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 16; i++) cyc(1, pat[i], 0, 0, 1, 1);
        lit(2, 5, 3, -1, -1);
        cyc(1, 2'b10, 0, 0, 1, 1); lit(3, 5, 3, -1, -1);
        repeat (16) cyc(1, 2'b00, 0, 0, 1, 1);
        lit(3, 1, 0, -1, -1);
        cyc(0, 2'b00, 0, 0, 1, 1);

        // Asynchronous reset with entries queued and window mid-count
        do_reset();
        cyc(1, 2'b11, 0, 0, 2, 0);
        for (int i = 0; i < 3; i++) cyc(1, 2'b10, 0, 0, 2, 0);
        cyc(1, 2'b00, 0, 0, 2, 0);
        cyc(1, 2'b00, 0, 0, 2, 0);
        @(negedge clk);
        #3 reset = 1'b1;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            cyc(($urandom_range(0, 9) != 0),
                (r < 6) ? 2'b10 : (r < 12) ? 2'b01 : (r < 15) ? 2'b00 : 2'b11,
                ($urandom_range(0, 15) == 0),
                $urandom_range(0, EMAX),
                $urandom_range(0, EMAX),
                ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            if (i == 1500) do_reset();
        end

        repeat (3) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
